mult_ctrl: RTL and testbench
============================

# mult_ctrl

Sequencing controller for the 4-bit register datapath: drives load, clear, add and shift strobes on the operand registers A and B and the product register P to run a shift-and-add unsigned multiply. It sits between the datapath registers and the top-level handshake: it accepts `start`, steps through N multiplier bits while sampling B's LSB, and reports `done`. It contains no arithmetic; the datapath owns A, B and P.

## Interface
Parameters:
- `N`, default 4: multiplier width, which equals the iteration count. Legal range is N ≥ 2.
- `CW`, default 2: counter width. Must satisfy 2^CW ≥ N.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a multiply. Sampled only in IDLE.
- `abort`  in  1: cancel an operation in progress. Sampled in every non-IDLE state.
- `b_lsb`  in  1: current LSB of datapath register B.
- `ld_ab`  out  1: load A and B from the operand inputs.
- `clr_p`  out  1: clear P.
- `add_p`  out  1: P[2N-1:N] ← P[2N-1:N] + A.
- `shift`  out  1: shift P and B right by one.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle completion pulse.
- `step`  out  CW: index of the bit currently being processed.

## Operation
- State register values: IDLE, LOAD, CHECK, ADD, SHIFT, DONE. Counter `step` is CW bits wide.
- Outputs are Moore, decoded from the registered state only. There are no combinational paths from inputs to outputs.
- IDLE: all strobes are 0. If `start`=1, go to LOAD; otherwise stay in IDLE.
- LOAD: `ld_ab`=1 and `clr_p`=1 in the same cycle. `step` ← 0. Go to CHECK.
- CHECK: no strobes. This cycle lets B settle. If `b_lsb`=1, go to ADD; otherwise go to SHIFT.
- ADD: `add_p`=1. Go to SHIFT.
- SHIFT: `shift`=1.
  - If `step`==N-1, go to DONE.
  - Otherwise `step` ← `step`+1 and go to CHECK.
- DONE: `done`=1 for exactly one cycle. Go to IDLE. `step` holds N-1.
- `abort`=1 in LOAD, CHECK, ADD or SHIFT: go to IDLE on the next edge. That state's strobe still asserts for the current cycle. `done` never fires and `step` ← 0.
- `abort` in DONE or IDLE has no effect.
- `start` in any state other than IDLE is ignored and is not queued.
- `start` and `abort` both high in IDLE: `start` wins (abort has no effect in IDLE).
- At most one of `ld_ab`/`clr_p` (as a pair), `add_p` and `shift` is high in any cycle.

## Timing
- Reset (`reset`=0), asynchronous: state=IDLE, `step`=0, and `ld_ab`, `clr_p`, `add_p`, `shift`, `busy`, `done` all 0 immediately. Reset release is synchronous to `clk`.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No `done`.
- Start accepted at edge k: LOAD occupies cycle k+1.
- Per bit: CHECK plus SHIFT is 2 cycles, plus 1 cycle of ADD when `b_lsb`=1.
- Busy length in cycles = 1 (LOAD) + 2N + popcount(B) + 1 (DONE). For N=4 this ranges from 10 (B=0) to 14 (B=4'hF).
- `done` is high in the last busy cycle. `busy` falls in the same cycle `done` falls.
- Back-to-back: with `start` held high, there is exactly one IDLE cycle between DONE and the next LOAD.

## Test plan
- Reset values: assert `reset`=0 mid-clock-cycle → all outputs 0 without waiting for an edge. Release and idle for 5 cycles → no strobes.
- Zero multiplier: B model=4'b0000 → LOAD, then 4×(CHECK, SHIFT), then DONE. 10 busy cycles, `add_p` never high, `step` sequence 0,0,1,1,2,2,3,3.
- Mixed bits: bench B model=4'b1011 (`b_lsb` = B[step]) with A=4'd5 → `add_p` pulses at steps 0, 1 and 3. `done` in the 13th busy cycle. The bench datapath gives P=8'd55.
- All ones: B=4'hF, A=4'hF → 14 busy cycles, 4 `add_p` pulses, P=8'd225. `start` pulsed again during busy → ignored, no second LOAD.
- Abort: assert `abort` during the ADD of step 1 (B=4'b0011) → `add_p` high that cycle, IDLE next cycle, `busy`=0, `step`=0, no `done`. A fresh `start` then completes normally.
- Back-to-back and reset mid-op: `start` held high for 3 operations → one IDLE cycle between each DONE and the following LOAD. `reset`=0 asserted in SHIFT of step 2 → immediate IDLE, and no `done` pulse ever appears for that operation.

Source files
------------

// File: rtl/mult_ctrl.sv
// mult_ctrl: shift-and-add multiply sequencer driving load/clear/add/shift strobes
module mult_ctrl #(
  parameter int N  = 4,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          b_lsb,
  output logic          ld_ab,
  output logic          clr_p,
  output logic          add_p,
  output logic          shift,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] step
);
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, ADD, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] step_nx;
  logic last, cancel;
  assign last   = step == CW'(N - 1);
  assign cancel = abort && state != IDLE && state != DONE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
    end
  always_comb begin
    state_nx = state;
    step_nx  = step;
    case (state)
      IDLE:  state_nx = start ? LOAD : IDLE;
      LOAD:  begin
        state_nx = CHECK;
        step_nx  = '0;
      end
      CHECK: state_nx = b_lsb ? ADD : SHIFT;
      ADD:   state_nx = SHIFT;
      SHIFT: begin
        state_nx = last ? DONE : CHECK;
        step_nx  = last ? step : step + CW'(1);
      end
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (cancel) begin
      state_nx = IDLE;
      step_nx  = '0;
    end
  end
  assign ld_ab = state == LOAD;
  assign clr_p = state == LOAD;
  assign add_p = state == ADD;
  assign shift = state == SHIFT;
  assign busy  = state != IDLE;
  assign done  = state == DONE;
endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: random and directed operations checked against a per-cycle trace model
module tb_mult_ctrl;
  logic clk = 0, reset = 1, start = 0, abort = 0, b_lsb;
  logic ld_ab, clr_p, add_p, shift, busy, done;
  logic [1:0] step;
  logic [3:0] a_in = 0, b_in = 0, ra = 0, rb = 0;
  logic [8:0] p = 0;
  logic [1:0] last_step = 0;
  int n_cmp = 0, n_bad = 0, op_id = 0;
  always #5 clk = ~clk;
  mult_ctrl #(.N(4), .CW(2)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .b_lsb(b_lsb),
    .ld_ab(ld_ab), .clr_p(clr_p), .add_p(add_p), .shift(shift),
    .busy(busy), .done(done), .step(step)
  );
  // bench-side datapath; P carries one extra bit to hold the add carry
  assign b_lsb = rb[0];
  always @(posedge clk) begin
    if (ld_ab) begin
      ra <= a_in;
      rb <= b_in;
    end
    if (clr_p) p <= '0;
    if (add_p) p[8:4] <= {1'b0, p[7:4]} + {1'b0, ra};
    if (shift) begin
      p  <= p >> 1;
      rb <= rb >> 1;
    end
  end
  function automatic logic [7:0] v(input logic ld, ad, sh, bu, dn, input logic [1:0] st);
    return {ld, ld, ad, sh, bu, dn, st};
  endfunction
  function automatic logic [7:0] obs();
    return {ld_ab, clr_p, add_p, shift, busy, done, step};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // expected trace: LOAD, then per bit CHECK [ADD] SHIFT, then DONE; cut at the abort point
  task automatic op(input logic [3:0] a, b, input int ab_idx, input bit chain);
    logic [7:0] e[$];
    op_id++;
    a_in = a;
    b_in = b;
    e.push_back(v(1, 0, 0, 1, 0, last_step));
    for (int i = 0; i < 4; i++) begin
      e.push_back(v(0, 0, 0, 1, 0, 2'(i)));
      if (b[i]) e.push_back(v(0, 1, 0, 1, 0, 2'(i)));
      e.push_back(v(0, 0, 1, 1, 0, 2'(i)));
    end
    e.push_back(v(0, 0, 0, 1, 1, 2'd3));
    if (ab_idx >= 0) begin
      e = e[0:ab_idx];
      last_step = 0;
    end else last_step = 3;
    for (int j = 0; j < e.size(); j++) begin
      @(negedge clk);
      check($sformatf("op%0d cyc%0d", op_id, j), obs(), e[j]);
      abort = (j == ab_idx) || (ab_idx < 0 && j == e.size() - 1 && $urandom % 2 == 1);
      start = (j == e.size() - 1) ? chain : (chain | 1'($urandom % 2));
    end
    @(negedge clk);
    check($sformatf("op%0d idle", op_id), obs(), v(0, 0, 0, 0, 0, last_step));
    if (ab_idx < 0) check($sformatf("op%0d prod", op_id), p[7:0], {4'b0, a} * {4'b0, b});
    abort = 0;
    start = chain;
  endtask
  task automatic reset_mid(input logic [3:0] a, b, input int idx, input logic [7:0] at);
    op_id++;
    a_in = a;
    b_in = b;
    for (int j = 0; j <= idx; j++) begin
      @(negedge clk);
      start = 0;
    end
    check("rst_mid_state", obs(), at);
    #2 reset = 0;
    #1 check("rst_mid_async", obs(), 0);
    @(negedge clk);
    reset = 1;
    last_step = 0;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      check($sformatf("rst_mid_quiet%0d", j), obs(), 0);
    end
  endtask
  initial begin
    bit ch = 0;
    #3 reset = 0;
    #1 check("rst_async", obs(), 0);
    @(negedge clk);
    reset = 1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check($sformatf("rst_idle%0d", j), obs(), 0);
    end
    start = 1; op(4'd0, 4'd0, -1, 0);
    @(negedge clk); start = 1; op(4'd5, 4'b1011, -1, 0);
    @(negedge clk); start = 1; op(4'hF, 4'hF, -1, 0);
    @(negedge clk); start = 1; op(4'd9, 4'b0011, 5, 0);
    @(negedge clk); start = 1; op(4'd7, 4'd6, -1, 0);
    @(negedge clk); start = 1; op(4'd3, 4'd5, -1, 1);
    op(4'd12, 4'd10, -1, 1);
    op(4'd6, 4'd9, -1, 0);
    @(negedge clk); start = 1; reset_mid(4'd4, 4'd0, 6, v(0, 0, 1, 1, 0, 2'd2));
    for (int i = 0; i < 40; i++) begin
      logic [3:0] a, b;
      int len, idx;
      a = 4'($urandom);
      b = 4'($urandom);
      len = 10 + $countones(b);
      idx = ($urandom % 4 == 0) ? int'($urandom_range(0, len - 2)) : -1;
      if (!ch) begin
        @(negedge clk);
        start = 1;
      end
      ch = (i < 39) && ($urandom % 2 == 1);
      op(a, b, idx, ch);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
